vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BACK, 48, horizontal back porch, pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BACK, 33, vertical back porch, lines

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, single system clock; all state on rising edge
- rst_n, input, 1, reset, synchronous, active-low
- pix_en, input, 1, pixel-advance qualifier; tie high for pixel clock = clk
- x, output, 10, current horizontal position, 0..H_TOTAL-1
- y, output, 10, current vertical position, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync, active-low
- vsync, output, 1, vertical sync, active-low
- display_on, output, 1, high when (x,y) lies in the visible area
- frame_start, output, 1, one-clk pulse on wrap to (0,0)
- frame_count, output, 8, frames completed, modulo 256

REQ-003 The reset port SHALL be the one clock domain's reset, synchronous, active-low: sampled only on rising clk, with no asynchronous path.

Function
REQ-004 H_TOTAL SHALL be H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 default); V_TOTAL SHALL be V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 default).
REQ-005 All outputs SHALL be registered; hsync, vsync and display_on SHALL be decoded from the same (x,y) presented in that cycle, with zero skew.
REQ-006 On a clk edge with pix_en=1, x SHALL increment by 1; at x=H_TOTAL-1, x SHALL wrap to 0 and y SHALL increment.
REQ-007 At x=H_TOTAL-1 and y=V_TOTAL-1 with pix_en=1, x and y SHALL both become 0 on the next edge.
REQ-008 On a clk edge with pix_en=0, x, y, hsync, vsync, display_on and frame_count SHALL hold their values.
REQ-009 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751 default).
REQ-010 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491 default), for every x of those lines.
REQ-011 display_on SHALL be 1 iff x < H_VISIBLE and y < V_VISIBLE.
REQ-012 frame_start SHALL be 1 for exactly one clk cycle: the cycle in which (x,y) first shows (0,0) after the REQ-007 wrap.
REQ-013 frame_start SHALL be 0 in all following cycles even if pix_en=0 holds (x,y) at (0,0).
REQ-014 frame_count SHALL increment by 1 in the same cycle frame_start asserts, and SHALL wrap 255->0.
REQ-015 x and y SHALL never leave 0..H_TOTAL-1 and 0..V_TOTAL-1; counter arithmetic SHALL be at least 10 bits, with no overflow.

Reset
REQ-016 When rst_n=0 at a clk edge, the block SHALL set x=0, y=0, hsync=1, vsync=1, display_on=1, frame_start=0 and frame_count=0, regardless of pix_en.
REQ-017 Reset asserted mid-line or mid-frame SHALL abort the frame with no residual pulse; frame_start SHALL NOT assert on reset release.
REQ-018 The first edge after release with pix_en=1 SHALL yield x=1, y=0.

Verification
REQ-019 Reset mid-frame: drive rst_n=0 for 1 clk at x=300, y=100 -> next cycle x=0, y=0, hsync=1, vsync=1, display_on=1, frame_count=0, frame_start=0.
REQ-020 Horizontal timing, pix_en=1: hsync low for exactly 96 consecutive clks (x=656..751) each 800-clk line; display_on falls when x reaches 640 and rises when x returns to 0.
REQ-021 Wraps: x=799 -> x=0, y+1; (799,524) -> (0,0) with frame_start=1 for 1 clk and frame_count incremented; frame period 420000 clks.
REQ-022 Vertical timing: vsync low exactly for y=490..491 (1600 clks); display_on=0 for all x on y=480..524.
REQ-023 Stalls: pix_en toggling 1,0,1,0 -> counters advance every 2 clks and hold on pix_en=0; frame period 840000 clks; frame_start still 1 clk wide.
REQ-024 frame_count wraps: run 256 frames from reset -> frame_count returns to 0 on the 256th frame_start.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and frame-start decode, all aligned to the same (x,y).
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_nxt, y_nxt;
    logic       x_end, y_end, frame_wrap;

    // Wrap is detected by equality before incrementing, so the counters
    // never step past the last position.
    always_comb begin
        x_end      = (x == H_LAST);
        y_end      = (y == V_LAST);
        frame_wrap = x_end && y_end;
        x_nxt      = x_end ? 10'd0 : x + 10'd1;
        y_nxt      = y;
        if (x_end)
            y_nxt = y_end ? 10'd0 : y + 10'd1;
    end

    // Sync/blank are decoded from the next position so they land in the
    // same register stage as x/y with no skew.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                x          <= x_nxt;
                y          <= y_nxt;
                hsync      <= !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
                vsync      <= !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
                display_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
                if (frame_wrap) begin
                    frame_start <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken raster (15x8) so whole
// frames and the 256-frame counter wrap fit in a short run.
module tb_vga_sync_gen;

    // H: 8 vis, 2 fp, 3 sync (x=10..12), 2 bp -> 15; V: 4 vis, 1 fp, 2 sync (y=5..6), 1 bp -> 8
    logic       clk = 1'b0;
    logic       rst_n, pix_en;
    logic [9:0] x, y;
    logic       hsync, vsync, display_on, frame_start;
    logic [7:0] frame_count;

    int n_chk = 0;
    int n_pass = 0;

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".x"}, x, 0);
        chk({tag, ".y"}, y, 0);
        chk({tag, ".hs"}, hsync, 1);
        chk({tag, ".vs"}, vsync, 1);
        chk({tag, ".de"}, display_on, 1);
        chk({tag, ".fs"}, frame_start, 0);
        chk({tag, ".fc"}, frame_count, 0);
    endtask

    initial begin
        int cyc, hl, vl, dc, pulses, x_hold;

        rst_n = 1'b0; pix_en = 1'b1;
        tickn(2);
        chk_reset_state("rst");

        rst_n = 1'b1;
        tick();
        chk("rel.x", x, 1);
        chk("rel.y", y, 0);
        chk("rel.fs", frame_start, 0);

        // horizontal edges of the first line
        tickn(6);
        chk("x7.x", x, 7);
        chk("x7.de", display_on, 1);
        tick();
        chk("x8.de", display_on, 0);
        tick();
        chk("x9.hs", hsync, 1);
        tick();
        chk("x10.hs", hsync, 0);
        tickn(2);
        chk("x12.hs", hsync, 0);
        tick();
        chk("x13.hs", hsync, 1);
        tickn(2);
        chk("wrap.x", x, 0);
        chk("wrap.y", y, 1);
        chk("wrap.de", display_on, 1);

        // rest of frame from (0,1): 105 positions
        cyc = 0; hl = 0; vl = 0; dc = 0;
        while (!frame_start && cyc < 200) begin
            if (!hsync) hl++;
            if (!vsync) vl++;
            if (display_on) dc++;
            tick();
            cyc++;
        end
        chk("sweep.cyc", cyc, 105);
        chk("sweep.hlow", hl, 21);
        chk("sweep.vlow", vl, 30);
        chk("sweep.de", dc, 24);
        chk("fw.x", x, 0);
        chk("fw.y", y, 0);
        chk("fw.fs", frame_start, 1);
        chk("fw.fc", frame_count, 1);
        chk("fw.hs", hsync, 1);
        chk("fw.vs", vsync, 1);

        // full frame period
        tick();
        chk("p.fs_low", frame_start, 0);
        chk("p.x", x, 1);
        cyc = 1;
        while (!frame_start && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("period", cyc, 120);
        chk("p.fc", frame_count, 2);

        // hold at (0,0): pulse must not repeat
        pix_en = 1'b0;
        tickn(3);
        chk("hold.fs", frame_start, 0);
        chk("hold.x", x, 0);
        chk("hold.y", y, 0);
        chk("hold.fc", frame_count, 2);
        chk("hold.de", display_on, 1);

        // pix_en toggling 1,0,1,0: frame every 240 clks
        pulses = 0; cyc = -1; x_hold = 0;
        for (int i = 0; i < 600; i++) begin
            pix_en = (i % 2 == 0);
            tick();
            if (i == 10) begin
                chk("stall.adv", x, 6);
                x_hold = x;
            end
            if (i == 11) chk("stall.hold", x, x_hold);
            if (frame_start) begin
                pulses++;
                if (pulses == 1) chk("stall.fs1", i, 238);
                if (pulses == 2) chk("stall.per", i - cyc, 240);
                cyc = i;
            end
        end
        chk("stall.pulses", pulses, 2);
        chk("stall.fc", frame_count, 4);

        // mid-frame reset at (7,6): in vsync, blanked
        pix_en = 1'b1;
        tickn(37);
        chk("mid.x", x, 7);
        chk("mid.y", y, 6);
        chk("mid.vs", vsync, 0);
        chk("mid.de", display_on, 0);
        rst_n = 1'b0;
        tick();
        chk_reset_state("midrst");
        rst_n = 1'b1; pix_en = 1'b0;
        tick();
        chk("rel2.fs", frame_start, 0);
        chk("rel2.x", x, 0);
        pix_en = 1'b1;
        tick();
        chk("rel2b.x", x, 1);
        chk("rel2b.y", y, 0);
        chk("rel2b.fs", frame_start, 0);

        // frame_count wraps on the 256th frame
        pulses = 0; cyc = 0;
        while (pulses < 256 && cyc < 256 * 120 + 200) begin
            tick();
            cyc++;
            if (frame_start) begin
                pulses++;
                if (pulses == 255) chk("fc255", frame_count, 255);
                if (pulses == 256) chk("fc_wrap", frame_count, 0);
            end
        end
        chk("wrap.pulses", pulses, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
